// File: rtl/serial_parity_frame_rx.sv
// Serial frame receiver feeding the even-parity checker: start bit, DATA_W data
// bits LSB first, one parity bit, one stop bit. Only stop-bit framing is judged here.
module serial_parity_frame_rx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              parity,
    output logic              valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               par_hold_q, par_hold_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               parity_q, parity_d;
    logic               valid_q, valid_d;
    logic               frame_err_q, frame_err_d;
    logic               sync1_q, sync2_q;
    logic               rx_s;

    // Two-flop synchronizer; the FSM only ever looks at rx_s.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            par_hold_q  <= 1'b0;
            data_q      <= '0;
            parity_q    <= 1'b0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            par_hold_q  <= par_hold_d;
            data_q      <= data_d;
            parity_q    <= parity_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_hold_d  = par_hold_q;
        data_d      = data_q;
        parity_d    = parity_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end

            // Re-check the start bit at its midpoint to reject glitches.
            S_START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BIT_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_PARITY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            S_PARITY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BIT_M1) begin
                    cnt_d      = '0;
                    par_hold_d = rx_s;
                    state_d    = S_STOP;
                end
            end

            // Leaving at mid stop bit lets a back-to-back start edge be caught.
            S_STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s) begin
                        data_d   = shift_q;
                        parity_d = par_hold_q;
                        valid_d  = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign data      = data_q;
    assign parity    = parity_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule
